// File: rtl/fifo_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_read_port
//  Purpose  : Read-clock-domain controller of a dual-clock asynchronous FIFO.
//             Synchronizes the Gray write pointer, keeps the binary/Gray read
//             pointer, produces a registered empty flag and presents popped
//             words through a registered valid/ready output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_read_port #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    input  logic                dout_ready,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] dout,
    output logic                dout_valid,
    output logic [ADDRSIZE:0]   rlevel
);

    localparam int c_PTRW = ADDRSIZE + 1;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [c_PTRW-1:0] f_gray2bin(input logic [c_PTRW-1:0] g);
        logic [c_PTRW-1:0] b;
        b = '0;
        b[c_PTRW-1] = g[c_PTRW-1];
        for (int i = c_PTRW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [c_PTRW-1:0]   r_rq1;
    logic [c_PTRW-1:0]   r_rq2;
    logic [c_PTRW-1:0]   r_rbin;
    logic [c_PTRW-1:0]   r_rptr;
    logic                r_rempty;
    logic [DATASIZE-1:0] r_dout;
    logic                r_dout_valid;

    logic                w_rinc;
    logic [c_PTRW-1:0]   w_rbinnext;
    logic [c_PTRW-1:0]   w_rgraynext;
    logic [c_PTRW-1:0]   w_wbin_sync;

    // A word is fetched whenever memory holds data and the output slot is free
    // or is being emptied on this same edge.
    assign w_rinc      = !r_rempty && (!r_dout_valid || dout_ready);
    assign w_rbinnext  = r_rbin + {{ADDRSIZE{1'b0}}, w_rinc};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;
    assign w_wbin_sync = f_gray2bin(r_rq2);

    // Two-flop synchronizer bringing the write pointer into the read domain.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= wptr;
            r_rq2 <= r_rq1;
        end
    end

    // Read pointer and empty flag; empty compares the next pointer so that
    // consecutive pops need no bubble.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_rbin   <= '0;
            r_rptr   <= '0;
            r_rempty <= 1'b1;
        end else begin
            r_rbin   <= w_rbinnext;
            r_rptr   <= w_rgraynext;
            r_rempty <= (w_rgraynext == r_rq2);
        end
    end

    // Output stage: load on a pop, drop valid when consumed without a refill,
    // otherwise hold the word stable.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_rinc) begin
            r_dout       <= rdata_mem;
            r_dout_valid <= 1'b1;
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign raddr      = r_rbin[ADDRSIZE-1:0];
    assign rptr       = r_rptr;
    assign rempty     = r_rempty;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    // Occupancy as seen through the synchronized write pointer (excludes dout).
    assign rlevel     = w_wbin_sync - r_rbin;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_read_port
//  Purpose  : Self-checking bench for fifo_read_port. A model write side
//             fills a behavioural memory and queues expected words; a monitor
//             compares every accepted output word against that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_read_port;

    logic       rclk = 1'b0;
    logic       rrst = 1'b0;
    logic [4:0] wptr = '0;
    logic [7:0] rdata_mem;
    logic       dout_ready = 1'b0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic [7:0] dout;
    logic       dout_valid;
    logic [4:0] rlevel;

    logic [7:0] mem [16];
    logic [7:0] exp_q [$];
    logic [4:0] wbin = '0;
    int         checks = 0;
    int         errors = 0;
    int         pop_count = 0;
    int         pop_base = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_dout = '0;

    fifo_read_port #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .wptr       (wptr),
        .rdata_mem  (rdata_mem),
        .dout_ready (dout_ready),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .rlevel     (rlevel)
    );

    assign rdata_mem = mem[raddr];

    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #2;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wbin[3:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 5'd1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rempty"},     32'(rempty),     32'd1);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_dout"},       32'(dout),       32'd0);
        chk({tag, "_rptr"},       32'(rptr),       32'd0);
        chk({tag, "_raddr"},      32'(raddr),      32'd0);
        chk({tag, "_rlevel"},     32'(rlevel),     32'd0);
    endtask

    // Monitor: a transfer happens on the coming edge when valid && ready here.
    always @(negedge rclk) begin
        if (rrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!dout_valid || dout !== prev_dout) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b dout=%0h expected valid=1 dout=%0h",
                             dout_valid, dout, prev_dout);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected no output", dout);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        errors++;
                        $display("FAIL data_order: got %0h expected %0h", dout, e);
                    end
                end
                pop_count++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // ---------------- reset state
        #1 rrst = 1'b1;
        #1 chk_reset_outputs("por");
        tick(); tick();
        rrst = 1'b0;
        tick();
        chk_reset_outputs("idle");

        // ---------------- single word, E1..E4 latency
        write_word(8'hA5);
        wptr = gray(wbin);
        tick();                                   // E1
        chk("single_e1_rempty", 32'(rempty), 32'd1);
        tick();                                   // E2
        chk("single_e2_rempty", 32'(rempty), 32'd1);
        chk("single_e2_rlevel", 32'(rlevel), 32'd1);
        tick();                                   // E3
        chk("single_e3_rempty", 32'(rempty), 32'd0);
        chk("single_e3_valid",  32'(dout_valid), 32'd0);
        tick();                                   // E4
        chk("single_e4_dout",   32'(dout), 32'hA5);
        chk("single_e4_valid",  32'(dout_valid), 32'd1);
        chk("single_e4_rptr",   32'(rptr), 32'd1);
        chk("single_e4_rempty", 32'(rempty), 32'd1);
        chk("single_e4_rlevel", 32'(rlevel), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("single_hold_valid", 32'(dout_valid), 32'd1);
            chk("single_hold_dout",  32'(dout), 32'hA5);
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("single_consumed_valid", 32'(dout_valid), 32'd0);
        chk("single_consumed_dout",  32'(dout), 32'hA5);

        // ---------------- burst of 16 from a fresh reset
        wbin = '0;
        wptr = '0;
        rrst = 1'b1;
        tick(); tick();
        rrst = 1'b0;
        pop_base = pop_count;
        dout_ready = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) write_word(8'(i));
        wptr = gray(wbin);                        // 0x18
        tick();                                   // E1
        tick();                                   // E2
        chk("burst_e2_rlevel", 32'(rlevel), 32'd16);
        chk("burst_e2_rempty", 32'(rempty), 32'd1);
        tick();                                   // E3
        chk("burst_e3_rempty", 32'(rempty), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk("burst_dout",   32'(dout), 32'(k));
            chk("burst_valid",  32'(dout_valid), 32'd1);
            chk("burst_rlevel", 32'(rlevel), 32'(15 - k));
            chk("burst_rempty", 32'(rempty), (k == 15) ? 32'd1 : 32'd0);
        end
        tick();
        chk("burst_end_valid",  32'(dout_valid), 32'd0);
        chk("burst_end_rempty", 32'(rempty), 32'd1);
        chk("burst_end_rptr",   32'(rptr), 32'h18);
        chk("burst_end_rlevel", 32'(rlevel), 32'd0);

        // ---------------- burst under random backpressure
        for (int i = 0; i < 16; i++) write_word(8'(i));
        wptr = gray(wbin);
        begin
            int guard;
            guard = 0;
            while ((exp_q.size() != 0) && (guard < 300)) begin
                dout_ready = 1'($urandom_range(0, 1));
                tick();
                guard++;
            end
            chk("bp_drained", 32'(exp_q.size()), 32'd0);
        end
        dout_ready = 1'b1;
        tick(); tick();
        chk("bp_end_valid", 32'(dout_valid), 32'd0);

        // ---------------- 40 words across the pointer wrap
        for (int b = 0; b < 5; b++) begin
            int guard;
            for (int i = 0; i < 8; i++) write_word(8'h40 + 8'(b * 8 + i));
            wptr = gray(wbin);
            guard = 0;
            do begin
                logic [4:0] rb;
                logic [4:0] occ;
                tick();
                guard++;
                rb  = 5'(pop_count - pop_base) + {4'd0, dout_valid};
                occ = wbin - rb;
                chk("wrap_rptr", 32'(rptr), 32'(gray(rb)));
                chk("wrap_level_bound", 32'(rlevel <= occ), 32'd1);
                if (!rempty) chk("wrap_not_falsely_nonempty", 32'(occ != 5'd0), 32'd1);
            end while (((exp_q.size() != 0) || dout_valid) && (guard < 40));
            chk("wrap_batch_drained", 32'(exp_q.size()), 32'd0);
        end
        chk("wrap_rempty", 32'(rempty), 32'd1);

        // ---------------- reset in the middle of a burst
        for (int i = 0; i < 16; i++) write_word(8'hC0 + 8'(i));
        wptr = gray(wbin);
        begin
            int start;
            int guard;
            start = pop_count;
            guard = 0;
            while ((pop_count - start < 5) && (guard < 50)) begin
                tick();
                guard++;
            end
            chk("mid_reached_5", 32'(pop_count - start >= 5), 32'd1);
        end
        rrst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        exp_q.delete();
        wbin = '0;
        wptr = '0;
        tick(); tick();
        rrst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_rempty", 32'(rempty), 32'd1);
            chk("post_rst_valid",  32'(dout_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
